// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential word fetches, pairs in-order
// responses with their PCs, buffers them for decode and flushes on redirect.
module fetch_unit #(
    parameter int addr_data_width = 32,
    parameter int FIFO_DEPTH      = 2
) (
    input  logic                       clk1,
    input  logic                       reset1,
    output logic                       imem_req,
    output logic [addr_data_width-1:0] imem_addr,
    input  logic                       imem_ready,
    input  logic                       imem_rvalid,
    input  logic [addr_data_width-1:0] imem_rdata,
    input  logic                       redirect_en,
    input  logic [addr_data_width-1:0] redirect_pc,
    output logic                       instr_valid,
    output logic [addr_data_width-1:0] instr_out,
    output logic [addr_data_width-1:0] instr_pc,
    input  logic                       instr_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]                DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]              ONE_C   = CW'(1);
    localparam logic [addr_data_width-1:0] PC_STEP = addr_data_width'(4);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [addr_data_width-1:0] r_pc;
    logic [CW-1:0]              r_outst;
    logic [CW-1:0]              r_disc;
    logic [CW-1:0]              r_count;
    logic [PW-1:0]              r_wptr;
    logic [PW-1:0]              r_rptr;
    logic [PW-1:0]              r_pq_wptr;
    logic [PW-1:0]              r_pq_rptr;
    logic [addr_data_width-1:0] r_fifo_instr [FIFO_DEPTH];
    logic [addr_data_width-1:0] r_fifo_pc    [FIFO_DEPTH];
    logic [addr_data_width-1:0] r_pq         [FIFO_DEPTH];

    logic                       w_acc;
    logic                       w_keep;
    logic                       w_pop;
    logic [CW:0]                w_occ;
    logic [CW-1:0]              w_outst_nxt;
    logic [CW-1:0]              w_disc_nxt;
    logic [addr_data_width-1:0] w_redir_pc;
    logic                       w_unused;

    assign w_unused   = ^redirect_pc[1:0];
    assign w_redir_pc = {redirect_pc[addr_data_width-1:2], 2'b00};

    // Every in-flight fetch has a reserved FIFO slot, so a response can never overflow.
    assign w_occ    = {1'b0, r_outst} + {1'b0, r_count};
    assign imem_req = !reset1 && !redirect_en && (r_state == S_RUN) && (w_occ < DEPTH_C);
    assign imem_addr = r_pc;

    assign w_acc  = imem_req && imem_ready;
    assign w_keep = imem_rvalid && !redirect_en && (r_state == S_RUN);
    assign w_pop  = instr_valid && instr_ready && !redirect_en;

    assign instr_valid = (r_count != '0);
    assign instr_out   = r_fifo_instr[r_rptr];
    assign instr_pc    = r_fifo_pc[r_rptr];

    always_comb begin
        w_outst_nxt = r_outst;
        if (w_acc && !imem_rvalid)
            w_outst_nxt = r_outst + ONE_C;
        else if (!w_acc && imem_rvalid && (r_outst != '0))
            w_outst_nxt = r_outst - ONE_C;
    end

    // In FLUSH the discard count equals the outstanding count, so a second
    // redirect reloading it from the outstanding count cannot double count.
    always_comb begin
        w_state_nxt = r_state;
        w_disc_nxt  = r_disc;
        if (redirect_en) begin
            w_disc_nxt  = w_outst_nxt;
            w_state_nxt = (w_outst_nxt != '0) ? S_FLUSH : S_RUN;
        end else if (r_state == S_FLUSH) begin
            if (imem_rvalid && (r_disc != '0))
                w_disc_nxt = r_disc - ONE_C;
            if ((r_disc == '0) || (imem_rvalid && (r_disc == ONE_C)))
                w_state_nxt = S_RUN;
        end
    end

    always_ff @(posedge clk1) begin
        if (reset1)
            r_state <= S_RUN;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk1) begin
        if (reset1) begin
            r_pc    <= '0;
            r_outst <= '0;
            r_disc  <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            r_disc  <= w_disc_nxt;
            if (redirect_en)
                r_pc <= w_redir_pc;
            else if (w_acc)
                r_pc <= r_pc + PC_STEP;
        end
    end

    always_ff @(posedge clk1) begin
        if (reset1) begin
            r_pq_wptr <= '0;
            r_pq_rptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_pq[i] <= '0;
        end else if (redirect_en) begin
            r_pq_wptr <= '0;
            r_pq_rptr <= '0;
        end else begin
            if (w_acc) begin
                r_pq[r_pq_wptr] <= r_pc;
                r_pq_wptr       <= r_pq_wptr + 1'b1;
            end
            if (w_keep)
                r_pq_rptr <= r_pq_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk1) begin
        if (reset1) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
        end else if (redirect_en) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_keep) begin
                r_fifo_instr[r_wptr] <= imem_rdata;
                r_fifo_pc[r_wptr]    <= r_pq[r_pq_rptr];
                r_wptr               <= r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_keep, w_pop})
                2'b10:   r_count <= r_count + ONE_C;
                2'b01:   r_count <= r_count - ONE_C;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus a program-order scoreboard
// on fetch addresses and decoded PCs, with directed and random scenarios.
module tb_fetch_unit;

    localparam int W = 32;
    localparam int D = 2;

    logic         clk1 = 1'b0;
    logic         reset1;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_ready;
    logic         imem_rvalid;
    logic [W-1:0] imem_rdata;
    logic         redirect_en;
    logic [W-1:0] redirect_pc;
    logic         instr_valid;
    logic [W-1:0] instr_out;
    logic [W-1:0] instr_pc;
    logic         instr_ready;

    fetch_unit #(.addr_data_width(W), .FIFO_DEPTH(D)) dut (
        .clk1        (clk1),
        .reset1      (reset1),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [W-1:0] addr;
        int           rdy;
        bit           stale;
    } mreq_t;

    mreq_t        mq[$];
    logic [W-1:0] pops_q[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    int           lat_min = 1;
    int           lat_max = 1;
    int           acc_cnt = 0;
    int           pop_cnt = 0;
    bit           gaps = 0;
    bit           prev_redirect = 0;
    logic [W-1:0] exp_fetch = '0;
    logic [W-1:0] exp_dec = '0;
    logic         s_req, s_valid;
    logic [W-1:0] s_addr, s_out, s_pc;

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock: present memory response, sample outputs, update the reference model.
    task automatic cycle();
        bit rv;
        int stale_n;
        @(negedge clk1);
        rv = 1'b0;
        if (!reset1 && mq.size() > 0 && mq[0].rdy <= cyc)
            rv = !(gaps && $urandom_range(0, 3) == 0);
        imem_rvalid = rv;
        if (rv) imem_rdata = mem_word(mq[0].addr);
        else    imem_rdata = $urandom;
        #1;
        s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
        s_out = instr_out; s_pc = instr_pc;
        if (reset1) begin
            mq.delete();
            exp_fetch = '0;
            exp_dec = '0;
            prev_redirect = 0;
        end else begin
            if (prev_redirect) begin
                checks++;
                if (instr_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_empty: instr_valid=%0b after redirect, required 0", instr_valid);
                end
            end
            stale_n = 0;
            foreach (mq[i]) if (mq[i].stale) stale_n++;
            checks++;
            if (imem_req === 1'b1 && (redirect_en || stale_n != 0)) begin
                errors++;
                $display("FAIL req_blocked: imem_req=1 redirect_en=%0b stale=%0d, required imem_req=0", redirect_en, stale_n);
            end
            if (imem_req && imem_ready) begin
                checks++;
                if (imem_addr !== exp_fetch) begin
                    errors++;
                    $display("FAIL fetch_addr: imem_addr=%h, required %h", imem_addr, exp_fetch);
                end
                checks++;
                if (((exp_fetch - exp_dec) >> 2) >= D) begin
                    errors++;
                    $display("FAIL capacity: request with %0d words pending, limit %0d", (exp_fetch - exp_dec) >> 2, D);
                end
                mq.push_back('{addr: imem_addr, rdy: cyc + int'($urandom_range(lat_min, lat_max)), stale: 1'b0});
                exp_fetch = exp_fetch + 32'd4;
                acc_cnt++;
            end
            if (instr_valid && instr_ready && !redirect_en) begin
                checks++;
                if (instr_pc !== exp_dec) begin
                    errors++;
                    $display("FAIL dec_pc: instr_pc=%h, required %h", instr_pc, exp_dec);
                end
                checks++;
                if (instr_out !== mem_word(exp_dec)) begin
                    errors++;
                    $display("FAIL dec_word: instr_out=%h, required %h", instr_out, mem_word(exp_dec));
                end
                pops_q.push_back(instr_pc);
                pop_cnt++;
                exp_dec = exp_dec + 32'd4;
            end
            if (rv) void'(mq.pop_front());
            if (redirect_en) begin
                foreach (mq[i]) mq[i].stale = 1'b1;
                exp_fetch = {redirect_pc[W-1:2], 2'b00};
                exp_dec = exp_fetch;
            end
            prev_redirect = redirect_en;
        end
        cyc++;
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        reset1 = 1'b1; redirect_en = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; instr_ready = 1'b0;
        cycle(); cycle();
        reset1 = 1'b0;
        pops_q.delete();
        acc_cnt = 0;
        gaps = 0; lat_min = 1; lat_max = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (s_req !== 1'b0 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: imem_req=%0b instr_valid=%0b, required 0 0", s_req, s_valid);
        end
        checks++;
        if (s_addr !== '0 || s_out !== '0 || s_pc !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h out=%h pc=%h, required all 0", s_addr, s_out, s_pc);
        end
        cycle();
        checks++;
        if (s_req !== 1'b1 || s_addr !== '0) begin
            errors++;
            $display("FAIL reset_release: imem_req=%0b addr=%h, required 1 00000000", s_req, s_addr);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        imem_ready = 1'b1; instr_ready = 1'b1;
        repeat (12) cycle();
        checks++;
        if (pops_q.size() < 3) begin
            errors++;
            $display("FAIL seq_count: %0d instructions decoded, required >= 3", pops_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (pops_q[i] !== 32'(4 * i)) begin
                    errors++;
                    $display("FAIL seq_pc%0d: pc=%h, required %h", i, pops_q[i], 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        imem_ready = 1'b1; instr_ready = 1'b0;
        repeat (6) cycle();
        checks++;
        if (acc_cnt != 2) begin
            errors++;
            $display("FAIL bp_reqs: %0d requests accepted, required 2", acc_cnt);
        end
        checks++;
        if (s_req !== 1'b0 || s_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: imem_req=%0b instr_valid=%0b, required 0 1", s_req, s_valid);
        end
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;
        cycle();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h8) begin
            errors++;
            $display("FAIL bp_resume: imem_req=%0b addr=%h, required 1 00000008", s_req, s_addr);
        end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        lat_min = 3; lat_max = 3;
        imem_ready = 1'b1; instr_ready = 1'b1;
        cycle(); cycle();
        checks++;
        if (acc_cnt != 2) begin
            errors++;
            $display("FAIL rf_setup: %0d outstanding, required 2", acc_cnt);
        end
        redirect_en = 1'b1; redirect_pc = 32'h0000_0103;
        cycle();
        redirect_en = 1'b0; lat_min = 1; lat_max = 1;
        cycle();
        checks++;
        if (s_req !== 1'b0 || s_addr !== 32'h100) begin
            errors++;
            $display("FAIL rf_flush1: imem_req=%0b addr=%h, required 0 00000100", s_req, s_addr);
        end
        cycle();
        checks++;
        if (s_req !== 1'b0) begin
            errors++;
            $display("FAIL rf_flush2: imem_req=%0b, required 0", s_req);
        end
        cycle();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h100) begin
            errors++;
            $display("FAIL rf_resume: imem_req=%0b addr=%h, required 1 00000100", s_req, s_addr);
        end
        repeat (6) cycle();
        checks++;
        if (pops_q.size() == 0 || pops_q[0] !== 32'h100) begin
            errors++;
            $display("FAIL rf_first_pc: %0d decoded, first pc=%h, required 00000100",
                     pops_q.size(), (pops_q.size() != 0) ? pops_q[0] : 32'hx);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        imem_ready = 1'b1; instr_ready = 1'b1;
        cycle();
        redirect_en = 1'b1; redirect_pc = 32'h0000_0200;
        cycle();
        redirect_en = 1'b0;
        cycle();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h200 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle: imem_req=%0b addr=%h instr_valid=%0b, required 1 00000200 0",
                     s_req, s_addr, s_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        imem_ready = 1'b0; instr_ready = 1'b1;
        redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect_en = 1'b0; imem_ready = 1'b1;
        cycle();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_first: imem_req=%0b addr=%h, required 1 fffffffc", s_req, s_addr);
        end
        cycle();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_second: imem_req=%0b addr=%h, required 1 00000000", s_req, s_addr);
        end
        repeat (6) cycle();
    endtask

    task automatic test_reset_full();
        do_reset();
        imem_ready = 1'b1; instr_ready = 1'b0;
        repeat (5) cycle();
        checks++;
        if (s_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstf_setup: instr_valid=%0b, required 1", s_valid);
        end
        reset1 = 1'b1;
        cycle();
        cycle();
        checks++;
        if (s_valid !== 1'b0 || s_addr !== '0 || s_req !== 1'b0) begin
            errors++;
            $display("FAIL rstf: instr_valid=%0b addr=%h imem_req=%0b, required 0 00000000 0",
                     s_valid, s_addr, s_req);
        end
        reset1 = 1'b0;
        imem_ready = 1'b0;
    endtask

    task automatic test_random();
        int start_pops;
        do_reset();
        lat_min = 1; lat_max = 4; gaps = 1;
        start_pops = pop_cnt;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                do_reset();
                lat_min = 1; lat_max = 4; gaps = 1;
            end
            imem_ready  = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect_en = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else                           redirect_pc = $urandom;
            cycle();
        end
        redirect_en = 1'b0;
        checks++;
        if (pop_cnt - start_pops < 100) begin
            errors++;
            $display("FAIL rand_progress: %0d instructions decoded, required >= 100", pop_cnt - start_pops);
        end
    endtask

    initial begin
        reset1 = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_en = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_flush();
        test_same_cycle();
        test_wrap();
        test_reset_full();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
